// File: rtl/Parameter.sv
// Shared build-time constants for the pipeline control slice.
package Parameter;

    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/StructPkg.sv
// Types and the hazard priority helper shared by the pipeline control logic.
package StructPkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic en_id;
        logic en_ex;
        logic en_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
    } ctrl_t;

    localparam ctrl_t CTRL_FREE = '{pc_en: 1'b1, en_id: 1'b1, en_ex: 1'b1, en_mem: 1'b1,
                                    flush_id: 1'b0, flush_ex: 1'b0, flush_mem: 1'b0};

    // Priority order: DMEM wait, branch, load-use, fetch wait, free run.
    function automatic ctrl_t hazard_rules(input logic dmem_wait, input logic flush_id,
                                           input logic stall_if, input logic imem_ready);
        ctrl_t c;
        c = CTRL_FREE;
        if (dmem_wait) begin
            c           = '0;
            c.flush_mem = 1'b1;
        end else if (flush_id) begin
            c.flush_id = 1'b1;
            c.flush_ex = 1'b1;
        end else if (stall_if) begin
            c.pc_en    = 1'b0;
            c.en_id    = 1'b0;
            c.flush_ex = 1'b1;
        end else if (!imem_ready) begin
            c.pc_en    = 1'b0;
            c.flush_id = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Single-cycle update; no backpressure, holds at all-ones once saturated.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with halt drain; controls are combinational from state and inputs.
// A DMEM wait freezes the whole pipe and pauses the drain count.
module pipeline_ctrl
    import StructPkg::*;
    import Parameter::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_IF,
    input  logic        i_flush_ID,
    input  logic        i_imem_ready,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ready,
    input  logic        i_halt_req,
    input  logic        i_resume_req,
    input  logic        i_cnt_clr,
    output logic        o_pc_en,
    output logic        o_en_ID,
    output logic        o_en_EX,
    output logic        o_en_MEM,
    output logic        o_flush_ID,
    output logic        o_flush_EX,
    output logic        o_flush_MEM,
    output logic        o_halted,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    ctrl_state_e   state_q, state_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    ctrl_t         ctl;
    logic          dmem_wait;
    logic          branch_take;
    logic          stall_inc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        dmem_wait   = i_dmem_req & ~i_dmem_ready;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ctl         = '0;
        o_halted    = 1'b0;
        branch_take = 1'b0;
        case (state_q)
            RUN: begin
                ctl         = hazard_rules(dmem_wait, i_flush_ID, i_stall_IF, i_imem_ready);
                branch_take = ~dmem_wait & i_flush_ID;
                if (i_halt_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                ctl         = hazard_rules(dmem_wait, i_flush_ID, i_stall_IF, i_imem_ready);
                branch_take = ~dmem_wait & i_flush_ID;
                if (!dmem_wait) begin
                    // Stop fetching new work; the PC only follows a branch redirect.
                    ctl.flush_id = 1'b1;
                    ctl.pc_en    = i_flush_ID;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q + CW'(1);
                    end
                end
            end
            HALTED: begin
                o_halted = 1'b1;
                if (i_resume_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign o_pc_en     = ctl.pc_en;
    assign o_en_ID     = ctl.en_id;
    assign o_en_EX     = ctl.en_ex;
    assign o_en_MEM    = ctl.en_mem;
    assign o_flush_ID  = ctl.flush_id;
    assign o_flush_EX  = ctl.flush_ex;
    assign o_flush_MEM = ctl.flush_mem;

    assign stall_inc = (state_q != HALTED) & ~ctl.pc_en;

    sat_counter #(.W(32)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_cnt_clr),
        .i_en    (stall_inc),
        .o_cnt   (o_stall_cnt)
    );

    sat_counter #(.W(32)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_cnt_clr),
        .i_en    (branch_take),
        .o_cnt   (o_flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int N = 3;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_stall_IF = 1'b0, i_flush_ID = 1'b0, i_imem_ready = 1'b1;
    logic        i_dmem_req = 1'b0, i_dmem_ready = 1'b0;
    logic        i_halt_req = 1'b0, i_resume_req = 1'b0, i_cnt_clr = 1'b0;
    logic        o_pc_en, o_en_ID, o_en_EX, o_en_MEM;
    logic        o_flush_ID, o_flush_EX, o_flush_MEM, o_halted;
    logic [31:0] o_stall_cnt, o_flush_cnt;

    pipeline_ctrl #(.DRAIN_CYCLES(N)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_stall_IF   (i_stall_IF),
        .i_flush_ID   (i_flush_ID),
        .i_imem_ready (i_imem_ready),
        .i_dmem_req   (i_dmem_req),
        .i_dmem_ready (i_dmem_ready),
        .i_halt_req   (i_halt_req),
        .i_resume_req (i_resume_req),
        .i_cnt_clr    (i_cnt_clr),
        .o_pc_en      (o_pc_en),
        .o_en_ID      (o_en_ID),
        .o_en_EX      (o_en_EX),
        .o_en_MEM     (o_en_MEM),
        .o_flush_ID   (o_flush_ID),
        .o_flush_EX   (o_flush_EX),
        .o_flush_MEM  (o_flush_MEM),
        .o_halted     (o_halted),
        .o_stall_cnt  (o_stall_cnt),
        .o_flush_cnt  (o_flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [6:0]  ctl;   // {pc, id, ex, mem, flush_id, flush_ex, flush_mem}
        logic        halted;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Model: mode 0 = running, 1 = draining, 2 = halted.
    int     m_mode = 0;
    int     m_dcnt = 0;
    longint m_sc = 0;
    longint m_fc = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic logic [6:0] model_ctl(input int mode, input logic st, input logic fl,
                                             input logic im, input logic dr, input logic dy);
        logic pc, id, ex, mem, fid, fex, fmem;
        if (mode == 2) return 7'b0;
        {pc, id, ex, mem, fid, fex, fmem} = 7'b1111_000;
        if (dr && !dy) begin
            {pc, id, ex, mem, fid, fex, fmem} = 7'b0000_001;
        end else begin
            if (fl)       begin fid = 1'b1; fex = 1'b1; end
            else if (st)  begin pc = 1'b0; id = 1'b0; fex = 1'b1; end
            else if (!im) begin pc = 1'b0; fid = 1'b1; end
            if (mode == 1) begin
                fid = 1'b1;
                pc  = fl;
            end
        end
        return {pc, id, ex, mem, fid, fex, fmem};
    endfunction

    task automatic step(input logic rn, input logic st, input logic fl, input logic im,
                        input logic dr, input logic dy, input logic h, input logic r, input logic c);
        exp_t e;
        logic dw;
        @(negedge i_clk);
        i_rst_n = rn; i_stall_IF = st; i_flush_ID = fl; i_imem_ready = im;
        i_dmem_req = dr; i_dmem_ready = dy; i_halt_req = h; i_resume_req = r; i_cnt_clr = c;
        if (!rn) begin
            m_mode = 0; m_dcnt = 0; m_sc = 0; m_fc = 0;
        end
        e.ctl    = model_ctl(m_mode, st, fl, im, dr, dy);
        e.halted = (m_mode == 2);
        e.sc     = m_sc[31:0];
        e.fc     = m_fc[31:0];
        exp_q.push_back(e);
        if (rn) begin
            dw = dr && !dy;
            if (m_mode != 2 && !e.ctl[6])     m_sc = (m_sc + 1 > CMAX) ? CMAX : m_sc + 1;
            if (m_mode != 2 && !dw && fl)     m_fc = (m_fc + 1 > CMAX) ? CMAX : m_fc + 1;
            if (c) begin m_sc = 0; m_fc = 0; end
            case (m_mode)
                0: if (h) begin m_mode = 1; m_dcnt = 0; end
                1: if (!dw) begin
                       if (m_dcnt == N - 1) m_mode = 2;
                       else m_dcnt++;
                   end
                default: if (r) m_mode = 0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so each cycle presents one response.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ctl", 32'({o_pc_en, o_en_ID, o_en_EX, o_en_MEM,
                                  o_flush_ID, o_flush_EX, o_flush_MEM}), 32'(e.ctl));
                check("halted", 32'(o_halted), 32'(e.halted));
                check("stall_cnt", o_stall_cnt, e.sc);
                check("flush_cnt", o_flush_cnt, e.fc);
            end
        end
    end

    initial begin
        // Reset with quiescent inputs
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use for one cycle
        step(1, 1, 0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // DMEM wait holds a branch for three cycles
        step(1, 0, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 1, 0, 0, 0);
        idle(2);

        // Halt, drain, resume
        step(1, 0, 0, 1, 0, 0, 1, 0, 0);
        idle(N + 2);
        step(1, 0, 0, 1, 0, 0, 0, 1, 0);
        idle(2);

        // Halt with a two-cycle DMEM wait inside DRAIN
        step(1, 0, 0, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 1, 0, 0, 0, 1, 0);
        idle(1);

        // Saturation of the stall counter
        @(posedge i_clk);
        #1;
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        @(negedge i_clk);
        release dut.u_stall_cnt.cnt_q;
        m_sc = 64'hFFFF_FFFE;
        #1;
        check("stall_preload", o_stall_cnt, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 1);
        idle(1);

        // Asynchronous reset while halted
        step(1, 0, 0, 1, 0, 0, 1, 0, 0);
        idle(N + 1);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_halted", 32'(o_halted), 32'd0);
        check("async_rst_enables", 32'({o_pc_en, o_en_ID, o_en_EX, o_en_MEM}), 32'hF);
        m_mode = 0; m_dcnt = 0; m_sc = 0; m_fc = 0;
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 80),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 3));
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge i_clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
